lut_update_scheduler: RTL and testbench

- Sequences writes into the dual 512x8 ROM/RAM lookup-table block used by the backlight dimming datapath.
- The pixel read stream always has priority and is passed straight through.
- Host or histogram-engine table updates are queued in a small FIFO and committed only during vertical blanking, so a frame never reads a half-updated curve.
- Sits between the update source, the pixel pipeline and the LUT memory; the memory's clock_dvi is tied to clock in this integration.

---
 rtl/lut_update_scheduler_if.sv | 44 ++++
 rtl/lut_update_scheduler.sv | 154 +++++++++++++++
 tb/tb_lut_update_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lut_update_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lut_update_scheduler_if                                                  |
// | Pixel read, table update and LUT memory signals of the update scheduler. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface lut_update_scheduler_if #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_AW    = 3
);
    logic                  rd_req;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic                  rd_valid;
    logic                  mem_en;
    logic [ADDR_BITS-1:0]  mem_raddr;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_we_rom;
    logic                  mem_we_ram;
    logic                  wr_req;
    logic                  wr_sel;
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  vblank;
    logic [FIFO_AW:0]      fifo_level;
    logic                  commit;
    logic                  overflow;
    logic                  clr_ovf;

    modport master (
        output rd_req, rd_addr, wr_req, wr_sel, wr_addr, wr_data, vblank, clr_ovf,
        input  rd_valid, mem_en, mem_raddr, mem_waddr, mem_wdata, mem_we_rom,
               mem_we_ram, wr_ready, fifo_level, commit, overflow
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_sel, wr_addr, wr_data, vblank, clr_ovf,
        output rd_valid, mem_en, mem_raddr, mem_waddr, mem_wdata, mem_we_rom,
               mem_we_ram, wr_ready, fifo_level, commit, overflow
    );
endinterface
`default_nettype wire

// File: rtl/lut_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lut_update_scheduler                                                     |
// | Queues LUT table updates and commits them in vertical blanking while the |
// | pixel read stream passes straight through. Optional macro:               |
// | LUT_UPDATE_ANYTIME_EN (also drain outside vblank in idle read cycles).   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lut_update_scheduler #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_AW    = 3
) (
    input  logic clock,
    input  logic reset_n,
    lut_update_scheduler_if.slave bus
);
    localparam int               c_EW    = 1 + ADDR_BITS + DATA_WIDTH;
    localparam int               c_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL  = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] c_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_STALL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_EW-1:0]       r_mem [c_DEPTH];
    logic [FIFO_AW:0]      r_wptr;
    logic [FIFO_AW:0]      r_rptr;
    logic                  r_wr_ready;
    logic                  r_overflow;
    logic                  r_commit;
    logic                  r_rd_valid;
    logic                  r_we_rom;
    logic                  r_we_ram;
    logic [ADDR_BITS-1:0]  r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [FIFO_AW:0]      w_level;
    logic [FIFO_AW:0]      w_level_nxt;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_sel;
    logic [ADDR_BITS-1:0]  w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_conflict;
    logic                  w_gate;
    logic                  w_exit;
    logic                  w_start;
    logic                  w_resume;

    assign w_level     = r_wptr - r_rptr;
    assign w_empty     = (w_level == '0);
    assign w_push      = bus.wr_req & r_wr_ready;
    assign {w_head_sel, w_head_addr, w_head_data} = r_mem[r_rptr[FIFO_AW-1:0]];
    // A write to the entry currently being read would race the read; hold it off.
    assign w_conflict  = bus.rd_req & (w_head_addr == bus.rd_addr);

`ifdef LUT_UPDATE_ANYTIME_EN
    // Outside vblank a read cycle simply withholds the pop; staying in DRAIN
    // lets the very next idle read cycle pop, so alternating reads cannot starve it.
    assign w_gate   = ~bus.vblank & bus.rd_req;
    assign w_exit   = 1'b0;
    assign w_start  = ~w_empty;
    assign w_resume = 1'b1;
`else
    assign w_gate   = 1'b0;
    assign w_exit   = ~bus.vblank;
    assign w_start  = bus.vblank & ~w_empty;
    assign w_resume = bus.vblank;
`endif

    assign w_pop       = (r_state == S_DRAIN) & ~w_empty & ~w_exit & ~w_conflict & ~w_gate;
    assign w_level_nxt = w_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= {bus.wr_sel, bus.wr_addr, bus.wr_data};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wr_ready <= 1'b1;
            r_overflow <= 1'b0;
            r_commit   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_we_rom   <= 1'b0;
            r_we_ram   <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
        end else begin
            r_rd_valid <= bus.rd_req;
            r_wr_ready <= (w_level_nxt != c_FULL);
            r_commit   <= (r_state == S_DONE);
            r_we_rom   <= w_pop & ~w_head_sel;
            r_we_ram   <= w_pop & w_head_sel;

            if (w_push) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_pop) begin
                r_rptr  <= r_rptr + c_ONE;
                r_waddr <= w_head_addr;
                r_wdata <= w_head_data;
            end

            if (bus.wr_req & ~r_wr_ready) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_empty || w_exit) begin
                        r_state <= S_IDLE;
                    end else if (w_conflict) begin
                        r_state <= S_STALL;
                    end else if (!w_gate && (w_level == c_ONE) && !w_push) begin
                        r_state <= S_DONE;
                    end
                end
                S_STALL: r_state <= w_resume ? S_DRAIN : S_IDLE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_en     = bus.rd_req;
    assign bus.mem_raddr  = bus.rd_addr;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.mem_waddr  = r_waddr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.mem_we_rom = r_we_rom;
    assign bus.mem_we_ram = r_we_ram;
    assign bus.wr_ready   = r_wr_ready;
    assign bus.fifo_level = w_level;
    assign bus.commit     = r_commit;
    assign bus.overflow   = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_lut_update_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lut_update_scheduler                                                  |
// | Scoreboard bench: queued updates must reach the LUT in order and on time.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lut_update_scheduler;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    lut_update_scheduler_if #(.ADDR_BITS(9), .DATA_WIDTH(8), .FIFO_AW(3)) bus ();

    lut_update_scheduler #(.ADDR_BITS(9), .DATA_WIDTH(8), .FIFO_AW(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_we = 0;
    int          n_commit = 0;
    logic        prev_rdreq = 1'b0;
    logic [17:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic sel, input logic [8:0] a, input logic [7:0] d);
        logic acc;
        acc = (sb.size() < 8);
        chk("wr_ready", {31'd0, bus.wr_ready}, {31'd0, acc});
        if (acc) sb.push_back({sel, a, d});
        bus.wr_req  = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick(1);
        bus.wr_req  = 1'b0;
    endtask

    task automatic wait_commit(input string tag);
        int c0;
        c0 = n_commit;
        for (int i = 0; i < 40 && n_commit == c0; i++) tick(1);
        chk(tag, n_commit - c0, 1);
    endtask

    // Every write that reaches the memory must be the oldest outstanding update.
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_rdreq = 1'b0;
        end else begin
            chk("rd_valid", {31'd0, bus.rd_valid}, {31'd0, prev_rdreq});
            if (bus.mem_we_rom || bus.mem_we_ram) begin
                n_we++;
                chk("we_exclusive", {31'd0, bus.mem_we_rom & bus.mem_we_ram}, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_we", 1, 0);
                end else begin
                    chk("wr_entry", {14'd0, bus.mem_we_ram, bus.mem_waddr, bus.mem_wdata},
                        {14'd0, sb.pop_front()});
                end
`ifdef LUT_UPDATE_ANYTIME_EN
                if (!bus.vblank) chk("pop_in_read_cycle", {31'd0, prev_rdreq}, 0);
`endif
            end
            if (bus.commit) n_commit++;
            prev_rdreq = bus.rd_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c_we;
        int c_cm;
        bus.rd_req = 0; bus.rd_addr = '0; bus.wr_req = 0; bus.wr_sel = 0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.vblank = 0; bus.clr_ovf = 0;
        tick(3);
        reset_n = 1'b1;
        tick(1);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_we", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        chk("rst_waddr", bus.mem_waddr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_flags", {bus.commit, bus.overflow, bus.rd_valid}, 0);

`ifndef LUT_UPDATE_ANYTIME_EN
        // Queue three RAM updates outside blanking, then open the window.
        push(1, 9'd5, 8'h10); push(1, 9'd6, 8'h20); push(1, 9'd7, 8'h30);
        tick(3);
        chk("t1_level", bus.fifo_level, 3);
        chk("t1_no_we", n_we, 0);
        bus.vblank = 1;
        tick(1); chk("t1_lat1", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        tick(1); chk("t1_we1", {bus.mem_we_rom, bus.mem_we_ram}, 1);
        chk("t1_addr1", bus.mem_waddr, 5);
        tick(1); chk("t1_we2", {bus.mem_we_rom, bus.mem_we_ram}, 1);
        tick(1); chk("t1_we3", {bus.mem_we_rom, bus.mem_we_ram}, 1);
        chk("t1_data3", bus.mem_wdata, 8'h30);
        tick(1); chk("t1_commit", bus.commit, 1);
        chk("t1_we_off", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        chk("t1_level0", bus.fifo_level, 0);
        tick(1); chk("t1_commit_1clk", bus.commit, 0);
        bus.vblank = 0;
        tick(1);

        // Fill past capacity; the ninth push is dropped.
        for (int i = 0; i < 9; i++) push(0, 9'h100 + 9'(i), 8'(i));
        chk("t2_level", bus.fifo_level, 8);
        chk("t2_not_ready", bus.wr_ready, 0);
        chk("t2_ovf", bus.overflow, 1);
        bus.clr_ovf = 1;
        push(0, 9'h1FE, 8'hEE);
        bus.clr_ovf = 0;
        chk("t2_set_wins", bus.overflow, 1);
        bus.clr_ovf = 1; tick(1); bus.clr_ovf = 0;
        chk("t2_clr", bus.overflow, 0);
        c_we = n_we;
        bus.vblank = 1;
        wait_commit("t2_commit");
        bus.vblank = 0;
        tick(1);
        chk("t2_writes", n_we - c_we, 8);
        chk("t2_ready_again", bus.wr_ready, 1);

        // Blanking closes after two pops; the rest waits for the next window.
        for (int i = 0; i < 5; i++) push(0, 9'h040 + 9'(i), 8'hA0 + 8'(i));
        c_we = n_we; c_cm = n_commit;
        bus.vblank = 1;
        tick(3);
        bus.vblank = 0;
        tick(3);
        chk("t3_two_writes", n_we - c_we, 2);
        chk("t3_level", bus.fifo_level, 3);
        chk("t3_no_commit", n_commit - c_cm, 0);
        bus.vblank = 1;
        wait_commit("t3_commit");
        bus.vblank = 0;
        tick(1);
        chk("t3_all_writes", n_we - c_we, 5);
        chk("t3_level0", bus.fifo_level, 0);

        // Head entry collides with an active pixel read.
        push(0, 9'h0A1, 8'h5A); push(1, 9'h0A2, 8'h6B);
        bus.rd_addr = 9'h0A1; bus.rd_req = 1; bus.vblank = 1;
        #1;
        chk("t4_mem_en", bus.mem_en, 1);
        chk("t4_mem_raddr", bus.mem_raddr, 9'h0A1);
        tick(1); chk("t4_we_a", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        tick(1); chk("t4_stall", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        bus.rd_req = 0;
        tick(1); chk("t4_we_b", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        tick(1); chk("t4_rom_we", {bus.mem_we_rom, bus.mem_we_ram}, 2);
        chk("t4_rom_addr", bus.mem_waddr, 9'h0A1);
        tick(1); chk("t4_ram_we", {bus.mem_we_rom, bus.mem_we_ram}, 1);
        wait_commit("t4_commit");
        bus.vblank = 0;
        tick(1);

        // Reset in the middle of a drain discards everything queued.
        for (int i = 0; i < 4; i++) push(1, 9'h020 + 9'(i), 8'hC0 + 8'(i));
        bus.vblank = 1;
        tick(2);
        chk("t5_draining", bus.mem_we_ram, 1);
        reset_n = 0;
        #1;
        chk("t5_we_low", {bus.mem_we_rom, bus.mem_we_ram}, 0);
        chk("t5_level0", bus.fifo_level, 0);
        chk("t5_ready", bus.wr_ready, 1);
        sb.delete();
        tick(2);
        reset_n = 1;
        c_we = n_we; c_cm = n_commit;
        tick(6);
        chk("t5_no_writes", n_we - c_we, 0);
        chk("t5_no_commit", n_commit - c_cm, 0);
        bus.vblank = 0;
`else
        // Outside blanking: pops happen only in cycles without a pixel read.
        bus.rd_addr = 9'h1FF; bus.rd_req = 1;
        push(1, 9'h030, 8'h44); push(0, 9'h031, 8'h55);
        tick(3);
        chk("any_held", n_we, 0);
        chk("any_level", bus.fifo_level, 2);
        c_cm = n_commit;
        for (int i = 0; i < 12; i++) begin
            bus.rd_req = ~bus.rd_req;
            tick(1);
        end
        bus.rd_req = 0;
        tick(3);
        chk("any_writes", n_we, 2);
        chk("any_commit", n_commit - c_cm, 1);
        chk("any_level0", bus.fifo_level, 0);
`endif
        tick(2);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
